hop_sel_kernel: RTL
===================

# hop_sel_kernel

Hop selection kernel (Core 5.1 Vol 2 Part B 2.6.2). It consumes the hopping control words X, Y1, Y2, A–F and F' produced by the hop control-word stage, and returns one 7-bit RF channel index per request. In connection state with AFH enabled, a channel the map marks unused is remapped to a used channel. The block sits between the control-word stage and the radio channel-programming logic.

## Interface
Parameters: none.

- clk_6M  in  1  6 MHz system clock
- rstz  in  1  reset, asynchronous, active-low
- hop_start_p  in  1  one-cycle request; samples all control words
- X  in  5  phase word
- Y1  in  1  slot-half bit (XOR onto C)
- Y2  in  6  slot-half offset (0 or 32)
- A  in  5  first-adder word
- B  in  4  XOR word
- C  in  5  permutation control, upper bits
- D  in  9  permutation control, lower bits
- E  in  7  second-adder word
- F  in  7  second-adder clock word (mod 79)
- Fprime  in  7  AFH second-adder clock word (mod N)
- regi_AFH_mode  in  1  remap enable
- regi_AFH_N  in  7  used-channel count N
- regi_AFH_chmap  in  79  bit i = 1 means RF channel i is used
- hop_chan  out  7  selected channel, held until the next result
- hop_valid_p  out  1  one-cycle strobe; hop_chan is valid
- hop_err_p  out  1  one-cycle strobe with hop_valid_p; remap failed or N illegal
- hop_busy  out  1  high from the cycle after a start until the valid strobe

## Operation
- The FSM states are IDLE, PERM, ADD, MAP, REDN and SCAN.
- **IDLE:** on hop_start_p, register all inputs, including chmap, N and mode, then go to PERM. hop_start_p is ignored while hop_busy is high.
- **PERM:**
  - Compute Z = ((X+A) mod 32) ^ {1'b0,B}.
  - Form control P[13:0] = {C ^ {5{Y1}}, D}.
  - Apply seven butterfly stages in order: (P13,P12), (P11,P10), (P9,P8), (P7,P6), (P5,P4), (P3,P2), (P1,P0).
  - Each bit swaps these Z positions when set: P0{0,1} P1{2,3} P2{1,2} P3{3,4} P4{0,4} P5{1,3} P6{0,2} P7{3,4} P8{1,4} P9{0,3} P10{2,4} P11{1,3} P12{0,3} P13{1,2}.
  - Register the result Zp, then go to ADD.
- **ADD:**
  - Compute k = (Zp+E+F+Y2) mod 79 on a 9-bit sum, max 268; reduce by up to three subtractions of 79.
  - Register kp = Zp+E+Fprime+Y2 unreduced (9 bits).
  - Go to MAP.
- **MAP:**
  - ch = bank(k), where bank(j) = 2j for j<40 and 2j−79 otherwise.
  - If AFH is off, or chmap[ch]=1: hop_chan ← ch, pulse valid, go to IDLE.
  - If N<20 or N>79: hop_chan ← ch, pulse valid and err, go to IDLE.
  - Otherwise go to REDN.
- **REDN:** each cycle, if kp ≥ N then kp ← kp−N. Otherwise clear pos and cnt to 0 and go to SCAN.
- **SCAN:**
  - Each cycle, test chmap[bank(pos)].
  - If the channel is used and cnt==kp: hop_chan ← bank(pos), pulse valid, go to IDLE.
  - If the channel is used and cnt≠kp: cnt++.
  - pos++.
  - If pos=78 is tested without a match: hop_chan ← ch, pulse valid and err, go to IDLE.
- Reset, including reset mid-operation, returns the FSM to IDLE and forces all outputs to 0.

## Timing
- Start seen at edge 0.
- Unremapped result: hop_valid_p is high in the cycle after edge 3, i.e. latency 3.
- Remapped result: let r be the number of N-subtractions and p the matching scan position. The valid strobe follows edge 5+r+p. Maximum latency is 5+13+78 = 96 cycles.
- hop_busy goes high after edge 0 and low in the same cycle hop_valid_p rises.
- A start may be issued in the cycle hop_valid_p is high. It is accepted, because the FSM is already in IDLE.

## Configuration
- **HOPSEL_AFH_EN defined:** full behaviour as above.
- **HOPSEL_AFH_EN undefined:**
  - REDN, SCAN, the kp and cnt registers and the chmap register are not built.
  - Fprime and regi_AFH_* are ignored.
  - Every result is bank(k) with latency 3.
  - hop_err_p is tied to 0.

## Test plan
- All inputs 0, start → hop_chan=0, valid 3 cycles later, err=0.
- X=1, D=9'h001, others 0 → Zp=2, k=2, hop_chan=4 at latency 3.
- Z=31 (X=31, A=B=0), E=127, F=78, Y2=32 → k=31, hop_chan=62. Then E=40 with the rest 0 → hop_chan=1.
- AFH on, N=20, chmap uses channels 0–19, E=60, rest 0:
  - ch 41 is unused; kp = 60 → 0 (r=3).
  - Result: hop_chan=0 at latency 8.
  - Repeat with E=50: kp=10, r=2, match at pos 40 → hop_chan=1 at latency 47.
- AFH on, N=5, ch unused → hop_chan=bank(k), valid and err at latency 3. With chmap=0 and N=20 → err at the end of the scan.
- Two more cases:
  - Start pulses during hop_busy are ignored; a start in the valid cycle is accepted.
  - rstz low in SCAN → outputs 0 and idle; the next start gives a correct result.

Source files
------------

// File: rtl/hop_sel_kernel_if.sv
// Request/result bundle for hop_sel_kernel: control words in, RF channel index out.
interface hop_sel_kernel_if;
    logic        hop_start_p;
    logic [4:0]  X;
    logic        Y1;
    logic [5:0]  Y2;
    logic [4:0]  A;
    logic [3:0]  B;
    logic [4:0]  C;
    logic [8:0]  D;
    logic [6:0]  E;
    logic [6:0]  F;
    logic [6:0]  Fprime;
    logic        regi_AFH_mode;
    logic [6:0]  regi_AFH_N;
    logic [78:0] regi_AFH_chmap;
    logic [6:0]  hop_chan;
    logic        hop_valid_p;
    logic        hop_err_p;
    logic        hop_busy;

    modport master (
        output hop_start_p, X, Y1, Y2, A, B, C, D, E, F, Fprime,
               regi_AFH_mode, regi_AFH_N, regi_AFH_chmap,
        input  hop_chan, hop_valid_p, hop_err_p, hop_busy
    );

    modport slave (
        input  hop_start_p, X, Y1, Y2, A, B, C, D, E, F, Fprime,
               regi_AFH_mode, regi_AFH_N, regi_AFH_chmap,
        output hop_chan, hop_valid_p, hop_err_p, hop_busy
    );
endinterface

// File: rtl/hop_sel_kernel.sv
// Hop selection kernel: permute/add control words into a 7-bit RF channel index.
// Define HOPSEL_AFH_EN to build the AFH unused-channel remap (REDN/SCAN path).
module hop_sel_kernel (
    input  logic            clk_6M,
    input  logic            rstz,
    hop_sel_kernel_if.slave hif
);
    typedef enum logic [2:0] {IDLE, PERM, ADD, MAP, REDN, SCAN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  x_q, a_q, c_q;
    logic [3:0]  b_q;
    logic        y1_q;
    logic [5:0]  y2_q;
    logic [8:0]  d_q;
    logic [6:0]  e_q, f_q;
    logic [4:0]  zp_q, zp_d;
    logic [6:0]  k_q, k_d;
    logic [6:0]  chan_q, chan_d;
    logic        valid_q, valid_d;
    logic        take;
    logic [4:0]  z_raw;
    logic [8:0]  k_sum;
    logic [6:0]  ch_k;

    function automatic logic [6:0] bank(input logic [6:0] j);
        return (j < 7'd40) ? {j[5:0], 1'b0} : 7'({j, 1'b0} - 8'd79);
    endfunction

    function automatic logic [4:0] swap2(input logic [4:0] z, input logic en,
                                        input int unsigned i, input int unsigned j);
        logic [4:0] r;
        r = z;
        if (en) begin
            r[i] = z[j];
            r[j] = z[i];
        end
        return r;
    endfunction

    // Pairs within each butterfly stage are disjoint, so bits are applied P13 down to P0.
    function automatic logic [4:0] permute(input logic [4:0] z, input logic [13:0] p);
        logic [4:0] r;
        r = swap2(z, p[13], 1, 2);
        r = swap2(r, p[12], 0, 3);
        r = swap2(r, p[11], 1, 3);
        r = swap2(r, p[10], 2, 4);
        r = swap2(r, p[9],  0, 3);
        r = swap2(r, p[8],  1, 4);
        r = swap2(r, p[7],  3, 4);
        r = swap2(r, p[6],  0, 2);
        r = swap2(r, p[5],  1, 3);
        r = swap2(r, p[4],  0, 4);
        r = swap2(r, p[3],  3, 4);
        r = swap2(r, p[2],  1, 2);
        r = swap2(r, p[1],  2, 3);
        r = swap2(r, p[0],  0, 1);
        return r;
    endfunction

    function automatic logic [6:0] mod79(input logic [8:0] s);
        logic [8:0] r;
        r = s;
        for (int unsigned i = 0; i < 3; i++)
            if (r >= 9'd79) r = r - 9'd79;
        return r[6:0];
    endfunction

    assign take  = (state_q == IDLE) && hif.hop_start_p;
    assign z_raw = (x_q + a_q) ^ {1'b0, b_q};
    assign k_sum = {4'b0, zp_q} + {2'b0, e_q} + {2'b0, f_q} + {3'b0, y2_q};
    assign ch_k  = bank(k_q);

`ifdef HOPSEL_AFH_EN
    logic        mode_q;
    logic [6:0]  n_q, fp_q;
    logic [78:0] chmap_q;
    logic [8:0]  kp_q, kp_d, kp_sum;
    logic [6:0]  pos_q, pos_d, cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [6:0]  scan_ch;
    logic        map_hit, n_bad, scan_used, scan_hit, kp_ge_n;

    assign kp_sum    = {4'b0, zp_q} + {2'b0, e_q} + {2'b0, fp_q} + {3'b0, y2_q};
    assign scan_ch   = bank(pos_q);
    assign map_hit   = !mode_q || chmap_q[ch_k];
    assign n_bad     = (n_q < 7'd20) || (n_q > 7'd79);
    assign scan_used = chmap_q[scan_ch];
    assign scan_hit  = scan_used && ({2'b00, cnt_q} == kp_q);
    assign kp_ge_n   = kp_q >= {2'b00, n_q};

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            mode_q  <= 1'b0;
            n_q     <= '0;
            fp_q    <= '0;
            chmap_q <= '0;
        end else if (take) begin
            mode_q  <= hif.regi_AFH_mode;
            n_q     <= hif.regi_AFH_N;
            fp_q    <= hif.Fprime;
            chmap_q <= hif.regi_AFH_chmap;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            kp_q  <= '0;
            pos_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            kp_q  <= kp_d;
            pos_q <= pos_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    logic afh_unused;
    assign afh_unused = ^{hif.Fprime, hif.regi_AFH_mode, hif.regi_AFH_N, hif.regi_AFH_chmap};
`endif

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            x_q  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            d_q  <= '0;
            e_q  <= '0;
            f_q  <= '0;
            y1_q <= 1'b0;
            y2_q <= '0;
        end else if (take) begin
            x_q  <= hif.X;
            a_q  <= hif.A;
            b_q  <= hif.B;
            c_q  <= hif.C;
            d_q  <= hif.D;
            e_q  <= hif.E;
            f_q  <= hif.F;
            y1_q <= hif.Y1;
            y2_q <= hif.Y2;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            zp_q    <= '0;
            k_q     <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            zp_q    <= zp_d;
            k_q     <= k_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hif.hop_start_p) state_d = PERM;
            PERM: state_d = ADD;
            ADD:  state_d = MAP;
`ifdef HOPSEL_AFH_EN
            MAP:  state_d = (map_hit || n_bad) ? IDLE : REDN;
            REDN: if (!kp_ge_n) state_d = SCAN;
            SCAN: if (scan_hit || (pos_q == 7'd78)) state_d = IDLE;
`else
            MAP:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        zp_d    = zp_q;
        k_d     = k_q;
        chan_d  = chan_q;
        valid_d = 1'b0;
`ifdef HOPSEL_AFH_EN
        kp_d    = kp_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            PERM: zp_d = permute(z_raw, {c_q ^ {5{y1_q}}, d_q});
            ADD: begin
                k_d = mod79(k_sum);
`ifdef HOPSEL_AFH_EN
                kp_d = kp_sum;
`endif
            end
            MAP: begin
`ifdef HOPSEL_AFH_EN
                if (map_hit || n_bad) begin
                    chan_d  = ch_k;
                    valid_d = 1'b1;
                    err_d   = !map_hit;
                end
`else
                chan_d  = ch_k;
                valid_d = 1'b1;
`endif
            end
`ifdef HOPSEL_AFH_EN
            REDN: begin
                if (kp_ge_n) begin
                    kp_d = kp_q - {2'b00, n_q};
                end else begin
                    pos_d = '0;
                    cnt_d = '0;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    chan_d  = scan_ch;
                    valid_d = 1'b1;
                end else begin
                    if (scan_used) cnt_d = cnt_q + 7'd1;
                    pos_d = pos_q + 7'd1;
                    if (pos_q == 7'd78) begin
                        chan_d  = ch_k;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        hif.hop_chan    = chan_q;
        hif.hop_valid_p = valid_q;
        hif.hop_busy    = (state_q != IDLE);
`ifdef HOPSEL_AFH_EN
        hif.hop_err_p   = err_q;
`else
        hif.hop_err_p   = 1'b0;
`endif
    end
endmodule
